down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter_if.sv | 26 ++
 rtl/down_counter.sv | 30 +++
 tb/tb_down_counter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/down_counter_if.sv
// Signal bundle for the down counter: the count-enable control plus the
// count value and its zero/wrap status flags.
interface down_counter_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             wrap;

    // No handshake: enable is a level sampled on every rising clk edge, and
    // count/zero/wrap are always valid once the first reset edge has occurred.
    modport master (
        output enable,
        input  count,
        input  zero,
        input  wrap
    );

    modport slave (
        input  enable,
        output count,
        output zero,
        output wrap
    );
endinterface

// File: rtl/down_counter.sv
// WIDTH-bit down counter with enable, synchronous reset, a combinational
// zero flag and a one-cycle registered pulse on 0 -> max underflow.
module down_counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Underflow falls out of modulo arithmetic; wrap is captured on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RESET_VALUE;
            wrap  <= 1'b0;
        end else begin
            if (enable) begin
                count <= count - ONE;
            end
            wrap <= enable && (count == '0);
        end
    end

    assign zero = (count == '0);
endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: a reference model pushes expected
// {count, zero, wrap} per edge and each is popped and compared after the edge.
module tb_down_counter;
    localparam int               WIDTH    = 4;
    localparam logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b1}};
    localparam int               EXP_W    = WIDTH + 2;

    logic clk;
    logic rst;

    down_counter_if #(.WIDTH(WIDTH)) dif ();

    down_counter #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RST_VAL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (dif.enable),
        .count  (dif.count),
        .zero   (dif.zero),
        .wrap   (dif.wrap)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [WIDTH-1:0] m_count = RST_VAL;
    logic             m_wrap  = 1'b0;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Drive one edge worth of inputs, predict the outcome, then check it.
    task automatic step(input logic rst_v, input logic en_v, input string tag);
        logic [EXP_W-1:0] exp_v;
        logic [WIDTH-1:0] e_count;
        logic             e_zero;
        logic             e_wrap;
        rst        = rst_v;
        dif.enable = en_v;
        if (rst_v) begin
            m_count = RST_VAL;
            m_wrap  = 1'b0;
        end else begin
            m_wrap = en_v && (m_count == 0);
            if (en_v) m_count = m_count - 1'b1;
        end
        exp_q.push_back({m_count, (m_count == 0), m_wrap});
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty at t=%0t", tag, $time);
        end else begin
            exp_v   = exp_q.pop_front();
            e_count = exp_v[EXP_W-1:2];
            e_zero  = exp_v[1];
            e_wrap  = exp_v[0];
            if (dif.count !== e_count) begin
                errors++;
                $display("FAIL %s count: got %0d expected %0d at t=%0t", tag, dif.count, e_count, $time);
            end
            checks++;
            if (dif.zero !== e_zero) begin
                errors++;
                $display("FAIL %s zero: got %b expected %b at t=%0t", tag, dif.zero, e_zero, $time);
            end
            checks++;
            if (dif.wrap !== e_wrap) begin
                errors++;
                $display("FAIL %s wrap: got %b expected %b at t=%0t", tag, dif.wrap, e_wrap, $time);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, "reset");
        step(1'b1, 1'b1, "reset_with_enable");
        step(1'b1, 1'b0, "reset_again");
    endtask

    task automatic test_count();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "count");
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, "wrap");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "to_seven");
        step(1'b1, 1'b1, "mid_reset");
        step(1'b0, 1'b1, "resume");
    endtask

    task automatic test_zero_hold();
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, "to_zero");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "zero_hold");
        step(1'b1, 1'b1, "reset_at_zero");
    endtask

    task automatic test_back_to_back();
        logic r;
        logic e;
        for (int i = 0; i < 60; i++) begin
            r = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, e, "random");
        end
    endtask

    initial begin
        rst        = 1'b1;
        dif.enable = 1'b0;
        test_reset();
        test_count();
        test_hold();
        test_wrap();
        test_mid_reset();
        test_zero_hold();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
